// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 64-deep synchronous FIFO. It drains the FIFO in
// bursts and presents the words on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
   parameter int DW      = 8,
   parameter int CW      = 8,
   parameter int BURST   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   input  logic [CW-1:0] fifo_count,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_dout,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    state;
   logic [5:0]    remain;
   logic [7:0]    timer;
   logic          inflight;
   logic          inflight_last;
   logic [1:0]    occ;
   logic [DW-1:0] d0, d1;
   logic          l0, l1;

   logic          pop;
   logic          push;
   logic [2:0]    level;
   logic          start_full;
   logic          start_timeout;

   assign pop  = m_valid && m_ready;
   assign push = inflight;

   // Words the skid buffer will hold after this cycle if nothing new is issued;
   // counting pop lets reads resume in the same cycle m_ready returns.
   assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   assign fifo_rd_en    = (state == S_BURST) && !fifo_empty && (remain != 6'd0) && (level < 3'd2);
   assign start_full    = fifo_count >= CW'(BURST);
   assign start_timeout = (fifo_count != '0) && (timer == 8'(TIMEOUT));

   assign m_valid = occ != 2'd0;
   assign m_data  = d0;
   assign m_last  = l0 && m_valid;
   assign busy    = state != S_IDLE;

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values; blocking assignments here would chain updates within a cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         remain <= 6'd0;
         timer  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_full) begin
                  state  <= S_BURST;
                  remain <= 6'(BURST);
                  timer  <= 8'd0;
               end else if (start_timeout) begin
                  state  <= S_BURST;
                  remain <= 6'(fifo_count);
                  timer  <= 8'd0;
               end else if (fifo_count == '0) begin
                  timer <= 8'd0;
               end else if (timer != 8'hFF) begin
                  timer <= timer + 8'd1;
               end
            end
            S_BURST: begin
               if (fifo_rd_en) begin
                  remain <= remain - 6'd1;
                  if (remain == 6'd1) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && m_last) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= fifo_rd_en;
         inflight_last <= fifo_rd_en && (remain == 6'd1);
      end
   end

   // NOTE: the buffer data registers are reset as well because m_data must read
   // zero out of reset; a plain storage array would normally be left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= 2'd0;
         d0  <= '0;
         d1  <= '0;
         l0  <= 1'b0;
         l1  <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  d0 <= fifo_dout;
                  l0 <= inflight_last;
               end else begin
                  d1 <= fifo_dout;
                  l1 <= inflight_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               d0  <= d1;
               l0  <= l1;
               l1  <= 1'b0;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  d0 <= fifo_dout;
                  l0 <= inflight_last;
               end else begin
                  d0 <= d1;
                  l0 <= l1;
                  d1 <= fifo_dout;
                  l1 <= inflight_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a behavioural FIFO feeds the DUT and a
// scoreboard of (word, last) pairs, partitioned into bursts up front, checks the stream.
module tb_fifo_burst_reader;

   localparam int DW      = 8;
   localparam int CW      = 8;
   localparam int BURST   = 16;
   localparam int TIMEOUT = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_last;
   logic          busy;

   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          force_empty = 1'b0;

   fifo_burst_reader #(.DW(DW), .CW(CW), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model of the 64-deep FIFO with registered dout.
   logic [DW-1:0] mem [64];
   int            wp, rp, cnt;

   assign fifo_count = 8'(cnt);
   assign fifo_empty = (cnt == 0) || force_empty;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wp        <= 0;
         rp        <= 0;
         cnt       <= 0;
         fifo_dout <= '0;
      end else begin
         if (fifo_rd_en && cnt != 0) begin
            fifo_dout <= mem[rp];
            rp        <= (rp + 1) % 64;
         end
         if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= (wp + 1) % 64;
         end
         cnt <= cnt + (wr_en ? 1 : 0) - ((fifo_rd_en && cnt != 0) ? 1 : 0);
      end
   end

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] wr_q[$];

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int phase = 0;
   int ready_mode = 0;
   int first_rd, first_valid, first_busy, t_full, t_nz, last_beat_cyc;
   int beats_scn, n_last_scn;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic          expect_idle = 1'b0;
   logic          occ_bad = 1'b0;
   logic          interlock_en = 1'b0;
   logic          forced_done = 1'b0;
   int            force_left = 0;
   logic [5:0]    rem_hold = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then sample 1 ns later.
   task automatic tick();
      beat_t e;
      @(negedge clk);
      cyc++;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = (phase % 4 == 0) || (phase % 4 == 3);
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      if (wr_q.size() > 0) begin
         wr_en   = 1'b1;
         wr_data = wr_q.pop_front();
      end else begin
         wr_en = 1'b0;
      end
      if (interlock_en && !forced_done && busy && dut.remain == 6'd10) begin
         force_left  = 6;
         forced_done = 1'b1;
         rem_hold    = dut.remain;
      end
      force_empty = force_left > 0;
      if (force_left > 0) force_left--;
      #1;
      if (force_empty) begin
         check("interlock_rd_en", fifo_rd_en, 0);
         check("interlock_remain", dut.remain, rem_hold);
      end
      if (dut.occ > 2'd2) occ_bad = 1'b1;
      if (stall_prev) begin
         check("stall_valid", m_valid, 1);
         check("stall_data", m_data, prev_data);
         check("stall_last", m_last, prev_last);
      end
      if (expect_idle) begin
         check("busy_after_last", busy, 0);
         expect_idle = 1'b0;
      end
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (busy && first_busy < 0) first_busy = cyc;
      if (fifo_count >= 8'(BURST) && t_full < 0) t_full = cyc;
      if (fifo_count != '0 && t_nz < 0) t_nz = cyc;
      if (m_valid && m_ready) begin
         check("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e.d);
            check("beat_last", m_last, e.l);
         end
         beats_scn++;
         if (m_last) begin
            n_last_scn++;
            last_beat_cyc = cyc;
            expect_idle   = 1'b1;
         end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
   endtask

   // Queue n words and their expected burst tags: full bursts while BURST words
   // remain, then one short timeout burst with the remainder.
   task automatic load_words(input int n, input bit fixed);
      beat_t e;
      int rem, idx, len;
      rem = n;
      idx = 0;
      while (rem > 0) begin
         len = (rem >= BURST) ? BURST : rem;
         for (int i = 0; i < len; i++) begin
            e.d = fixed ? 8'hA1 + 8'(idx) : 8'($urandom);
            e.l = (i == len - 1);
            exp_q.push_back(e);
            wr_q.push_back(e.d);
            idx++;
         end
         rem -= len;
      end
   endtask

   task automatic start_scenario(input int mode);
      ready_mode    = mode;
      phase         = 0;
      first_rd      = -1;
      first_valid   = -1;
      first_busy    = -1;
      t_full        = -1;
      t_nz          = -1;
      last_beat_cyc = -1;
      beats_scn     = 0;
      n_last_scn    = 0;
      forced_done   = 1'b0;
   endtask

   task automatic run_scenario(input int n, input int mode, input bit fixed, input bit interlock);
      int guard;
      start_scenario(mode);
      interlock_en = interlock;
      load_words(n, fixed);
      guard = 0;
      while (exp_q.size() != 0 || wr_q.size() != 0 || busy) begin
         tick();
         guard++;
         if (guard > 3000) begin
            check("scenario_drained", 0, 1);
            break;
         end
      end
      tick();
      interlock_en = 1'b0;
   endtask

   task automatic reset_mid_burst();
      int   guard;
      logic quiet;
      start_scenario(0);
      load_words(16, 1'b0);
      guard = 0;
      while (beats_scn < 5 && guard < 500) begin
         tick();
         guard++;
      end
      check("reset_reached_beat5", beats_scn, 5);
      rst = 1'b1;
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_state_idle", dut.state, 0);
      check("rst_occ", dut.occ, 0);
      exp_q.delete();
      wr_q.delete();
      stall_prev  = 1'b0;
      expect_idle = 1'b0;
      tick();
      tick();
      rst   = 1'b0;
      quiet = 1'b0;
      repeat (40) begin
         tick();
         if (m_valid || busy || fifo_rd_en) quiet = 1'b1;
      end
      check("post_reset_quiet", quiet, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("reset_rd_en", fifo_rd_en, 0);
      check("reset_valid", m_valid, 0);
      check("reset_data", m_data, 0);
      check("reset_last", m_last, 0);
      check("reset_busy", busy, 0);
      check("reset_occ", dut.occ, 0);
      check("reset_remain", dut.remain, 0);
      check("reset_timer", dut.timer, 0);
      check("reset_inflight", dut.inflight, 0);
      rst = 1'b0;

      // Full burst with m_ready held high.
      run_scenario(16, 0, 1'b0, 1'b0);
      check("full_first_rd_lat", 32'(first_rd - t_full), 1);
      check("full_first_valid_lat", 32'(first_valid - t_full), 3);
      check("full_throughput", 32'(last_beat_cyc - first_valid), 15);
      check("full_one_last", n_last_scn, 1);

      // Backpressure with m_ready pattern 1,0,0,1.
      run_scenario(16, 1, 1'b0, 1'b0);
      check("bp_beats", beats_scn, 16);

      // Timeout-triggered short burst of 0xA1..0xA3.
      run_scenario(3, 0, 1'b1, 1'b0);
      check("timeout_start", 32'(first_busy - t_nz), TIMEOUT + 1);
      check("timeout_beats", beats_scn, 3);

      // Back-to-back: 16, 16 and an 8-word timeout burst.
      run_scenario(40, 2, 1'b0, 1'b0);
      check("b2b_beats", beats_scn, 40);
      check("b2b_bursts", n_last_scn, 3);

      reset_mid_burst();

      // Empty interlock during BURST.
      run_scenario(16, 0, 1'b0, 1'b1);
      check("interlock_applied", forced_done, 1);
      check("interlock_beats", beats_scn, 16);

      for (int s = 0; s < 6; s++) begin
         run_scenario(int'($urandom_range(1, 60)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end

      check("occ_le_2", occ_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
